// File: rtl/cga_vram_arbiter.sv
// Shares the CGA video RAM between display fetch and ISA CPU cycles in the B8000h window.
// Display always wins; CPU writes are posted through a 2-entry buffer, reads stall via bus_rdy.
module cga_vram_arbiter #(
    parameter logic [19:0] FRAMEBUFFER_ADDR = 20'hB8000,
    parameter int unsigned ACCESS_CYCLES    = 2,
    parameter bit          USE_BUS_WAIT     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] bus_a,
    input  logic [7:0]  bus_d,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic        bus_aen,
    input  logic        tandy_32k,
    input  logic        vram_read,
    input  logic        isa_op_enable,
    input  logic [18:0] disp_addr,
    input  logic [7:0]  ram_d,
    output logic [18:0] ram_a,
    output logic        ram_we_l,
    output logic [7:0]  ram_dout,
    output logic [7:0]  bus_out_mem,
    output logic        bus_mem_dir,
    output logic        bus_rdy,
    output logic        overflow
);

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {IDLE, WR_ACC, RD_ACC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      memr_sync, memw_sync;
    logic            memr_prev, memw_prev;
    logic            window, rd_req, wr_req, rd_accept;
    logic [AW-1:0]   cpu_addr;
    logic            grant, last, pop, full, empty;

    logic [AW-1:0]   fifo_addr [2];
    logic [DW-1:0]   fifo_data [2];
    logic            wptr, rptr;
    logic [1:0]      count;
    logic            hold_valid;
    logic [AW-1:0]   hold_addr;
    logic [DW-1:0]   hold_data;

    logic            push, hold_set, hold_push, drop;
    logic [AW-1:0]   push_addr;
    logic [DW-1:0]   push_data;

    logic            rd_pend;
    logic [AW-1:0]   rd_addr;
    logic            rdy_q;
    logic            cpu_phase;

    // Strobe synchronizers; idle-high reset value avoids a false edge out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            memr_sync <= 2'b11;
            memw_sync <= 2'b11;
            memr_prev <= 1'b1;
            memw_prev <= 1'b1;
        end else begin
            memr_sync <= {memr_sync[0], bus_memr_l};
            memw_sync <= {memw_sync[0], bus_memw_l};
            memr_prev <= memr_sync[1];
            memw_prev <= memw_sync[1];
        end
    end

    assign window    = ~bus_aen & (bus_a[19:15] == FRAMEBUFFER_ADDR[19:15]);
    assign cpu_addr  = {4'h0, tandy_32k & bus_a[14], bus_a[13:0]};
    assign rd_req    = memr_prev & ~memr_sync[1] & window;
    assign wr_req    = memw_prev & ~memw_sync[1] & window;
    assign rd_accept = rd_req & ~rd_pend & (state != DONE);

    assign grant = isa_op_enable & ~vram_read;
    assign last  = (cnt == CW'(ACCESS_CYCLES - 1));
    assign pop   = (state == WR_ACC) & grant & last;
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    // A stalled write lands the clock after a pop; a fresh write may ride a same-clock pop
    always_comb begin
        push      = 1'b0;
        hold_set  = 1'b0;
        hold_push = 1'b0;
        drop      = 1'b0;
        push_addr = cpu_addr;
        push_data = bus_d;
        if (hold_valid) begin
            if (!full) begin
                push      = 1'b1;
                hold_push = 1'b1;
                push_addr = hold_addr;
                push_data = hold_data;
            end
        end else if (wr_req) begin
            if (!full || pop) begin
                push = 1'b1;
            end else if (USE_BUS_WAIT) begin
                hold_set = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr] <= push_addr;
            fifo_data[wptr] <= push_data;
        end
        if (hold_set) begin
            hold_addr <= cpu_addr;
            hold_data <= bus_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            count      <= 2'd0;
            hold_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            count <= count + 2'(push) - 2'(pop);
            if (hold_set)       hold_valid <= 1'b1;
            else if (hold_push) hold_valid <= 1'b0;
            if (drop) overflow <= 1'b1;
        end
    end

    // Access sequencer: writes before reads so a read sees earlier posted writes
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rd_pend     <= 1'b0;
            rd_addr     <= '0;
            bus_out_mem <= '0;
            rdy_q       <= 1'b1;
            bus_mem_dir <= 1'b0;
        end else begin
            bus_mem_dir <= ~memr_sync[1] & window;
            if (rd_accept) begin
                rd_pend <= 1'b1;
                rd_addr <= cpu_addr;
                rdy_q   <= 1'b0;
            end
            if (hold_set)       rdy_q <= 1'b0;
            else if (hold_push) rdy_q <= 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant && !empty)        state <= WR_ACC;
                    else if (grant && rd_pend)  state <= RD_ACC;
                end
                WR_ACC: begin
                    if (!grant || last) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RD_ACC: begin
                    if (!grant) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (last) begin
                        bus_out_mem <= ram_d;
                        rd_pend     <= 1'b0;
                        rdy_q       <= 1'b1;
                        cnt         <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (memr_sync[1]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port mux; an abort hands the port back to the display in the same clock
    assign cpu_phase = ((state == WR_ACC) || (state == RD_ACC)) & grant;

    always_comb begin
        ram_a    = disp_addr;
        ram_we_l = 1'b1;
        ram_dout = fifo_data[rptr];
        if (cpu_phase) begin
            ram_a    = (state == WR_ACC) ? fifo_addr[rptr] : rd_addr;
            ram_we_l = (state != WR_ACC);
        end
    end

    assign bus_rdy = USE_BUS_WAIT ? rdy_q : 1'b1;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Scoreboard bench for cga_vram_arbiter: RAM write runs and CPU read data are checked
// against expectations queued when the ISA cycles are driven.
module tb_cga_vram_arbiter;

    localparam int unsigned AC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_memr_l, bus_memw_l, bus_aen, tandy_32k;
    logic        vram_read, isa_op_enable;
    logic [18:0] disp_addr;
    logic [7:0]  ram_d;

    logic [18:0] ram_a, nw_ram_a;
    logic        ram_we_l, nw_ram_we_l;
    logic [7:0]  ram_dout, nw_ram_dout;
    logic [7:0]  bus_out_mem, nw_bus_out_mem;
    logic        bus_mem_dir, nw_bus_mem_dir;
    logic        bus_rdy, nw_bus_rdy;
    logic        overflow, nw_overflow;

    cga_vram_arbiter #(.ACCESS_CYCLES(AC), .USE_BUS_WAIT(1'b1)) dut (
        .clk(clk), .reset(reset), .bus_a(bus_a), .bus_d(bus_d),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_aen(bus_aen),
        .tandy_32k(tandy_32k), .vram_read(vram_read), .isa_op_enable(isa_op_enable),
        .disp_addr(disp_addr), .ram_d(ram_d), .ram_a(ram_a), .ram_we_l(ram_we_l),
        .ram_dout(ram_dout), .bus_out_mem(bus_out_mem), .bus_mem_dir(bus_mem_dir),
        .bus_rdy(bus_rdy), .overflow(overflow)
    );

    cga_vram_arbiter #(.ACCESS_CYCLES(AC), .USE_BUS_WAIT(1'b0)) dut_nw (
        .clk(clk), .reset(reset), .bus_a(bus_a), .bus_d(bus_d),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_aen(bus_aen),
        .tandy_32k(tandy_32k), .vram_read(vram_read), .isa_op_enable(isa_op_enable),
        .disp_addr(disp_addr), .ram_d(ram_d), .ram_a(nw_ram_a), .ram_we_l(nw_ram_we_l),
        .ram_dout(nw_ram_dout), .bus_out_mem(nw_bus_out_mem), .bus_mem_dir(nw_bus_mem_dir),
        .bus_rdy(nw_bus_rdy), .overflow(nw_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [26:0] wr_q [$];
    logic [7:0]  rd_q [$];

    int          run_len = 0;
    logic [18:0] run_addr;
    logic [7:0]  run_data;
    int          wr_done = 0;
    int          last_end_cyc = 0;
    int          rdy_low_cnt = 0;
    int          we_low_cnt = 0;
    int          nw_rdy_low_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write-run monitor: a full-length run of ram_we_l low is one retired posted write
    always @(negedge clk) begin
        if (!bus_rdy)    rdy_low_cnt++;
        if (!nw_bus_rdy) nw_rdy_low_cnt++;
        if (!ram_we_l) begin
            we_low_cnt++;
            if (run_len == 0) begin
                run_addr = ram_a;
                run_data = ram_dout;
            end
            run_len++;
        end else if (run_len > 0) begin
            if (run_len >= AC) begin
                logic [26:0] e;
                check_eq("wr_len", run_len, AC);
                check_eq("wr_expected", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    check_eq("wr_addr", run_addr, e[26:8]);
                    check_eq("wr_data", run_data, e[7:0]);
                end
                wr_done++;
                last_end_cyc = cyc;
            end
            run_len = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [19:0] a, input logic [7:0] d,
                             input bit exp_valid, input logic [18:0] exp_a);
        if (exp_valid) wr_q.push_back({exp_a, d});
        bus_a = a;
        bus_d = d;
        bus_memw_l = 1'b0;
        step(5);
        bus_memw_l = 1'b1;
        step(3);
    endtask

    task automatic wait_rdy(input logic val, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_rdy === val) break;
        end
        check_eq(tag, bus_rdy, val);
    endtask

    task automatic wait_we_low(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ram_we_l === 1'b0) break;
        end
        check_eq(tag, ram_we_l, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        reset = 1'b1;
        bus_a = '0; bus_d = '0;
        bus_memr_l = 1'b1; bus_memw_l = 1'b1; bus_aen = 1'b0; tandy_32k = 1'b0;
        vram_read = 1'b0; isa_op_enable = 1'b0;
        disp_addr = 19'h12345; ram_d = 8'h00;
        step(3);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_rdy", bus_rdy, 1);
        check_eq("rst_we", ram_we_l, 1);
        check_eq("rst_dout", bus_out_mem, 0);
        check_eq("rst_dir", bus_mem_dir, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_ram_a", ram_a, 19'h12345);

        // Single uncontested write
        step(1);
        isa_op_enable = 1'b1;
        rdy_low_cnt = 0; we_low_cnt = 0; c0 = wr_done;
        cpu_write(20'hB8010, 8'h5A, 1'b1, 19'h00010);
        step(4);
        check_eq("w1_rdy_never_low", rdy_low_cnt, 0);
        check_eq("w1_we_cycles", we_low_cnt, AC);
        check_eq("w1_done", wr_done, c0 + 1);

        // Three writes with no slot: third stalls; drain in order
        isa_op_enable = 1'b0;
        c0 = wr_done;
        cpu_write(20'hB8001, 8'h11, 1'b1, 19'h00001);
        cpu_write(20'hB8002, 8'h22, 1'b1, 19'h00002);
        cpu_write(20'hB8003, 8'h33, 1'b1, 19'h00003);
        @(negedge clk);
        check_eq("full_rdy_low", bus_rdy, 0);
        check_eq("nw_overflow", nw_overflow, 1);
        check_eq("ovf_wait_mode", overflow, 0);
        check_eq("no_slot_no_write", wr_done, c0);
        step(1);
        isa_op_enable = 1'b1;
        wait_rdy(1'b1, 30, "full_rdy_rise");
        check_eq("rdy_after_pop", cyc - last_end_cyc, 1);
        step(20);
        check_eq("drain_count", wr_done, c0 + 3);
        check_eq("drain_sb_empty", wr_q.size(), 0);

        // Read behind a pending write
        isa_op_enable = 1'b0;
        c0 = wr_done;
        cpu_write(20'hB8020, 8'h77, 1'b1, 19'h00020);
        rd_q.push_back(8'hC3);
        ram_d = 8'hC3;
        bus_a = 20'hB8010;
        bus_memr_l = 1'b0;
        wait_rdy(1'b0, 8, "rd_rdy_low");
        step(2);
        isa_op_enable = 1'b1;
        wait_rdy(1'b1, 30, "rd_rdy_high");
        check_eq("rd_after_wr", wr_done, c0 + 1);
        check_eq("rd_data", bus_out_mem, rd_q.pop_front());
        check_eq("rd_dir", bus_mem_dir, 1);
        step(1);
        ram_d = 8'h00;
        step(3);
        @(negedge clk);
        check_eq("rd_hold", bus_out_mem, 8'hC3);
        check_eq("rd_hold_rdy", bus_rdy, 1);
        step(1);
        bus_memr_l = 1'b1;
        step(4);
        @(negedge clk);
        check_eq("rd_dir_off", bus_mem_dir, 0);
        check_eq("rd_end_rdy", bus_rdy, 1);

        // Display steals the 2nd clock of a write access
        step(1);
        c0 = wr_done;
        wr_q.push_back({19'h00030, 8'hAB});
        bus_a = 20'hB8030; bus_d = 8'hAB; bus_memw_l = 1'b0;
        disp_addr = 19'h5555A;
        wait_we_low(10, "abort_start");
        @(posedge clk); #1;
        vram_read = 1'b1;
        @(negedge clk);
        check_eq("abort_we", ram_we_l, 1);
        check_eq("abort_ram_a", ram_a, 19'h5555A);
        @(posedge clk); #1;
        vram_read = 1'b0;
        step(2);
        bus_memw_l = 1'b1;
        step(10);
        check_eq("abort_pop_once", wr_done, c0 + 1);
        check_eq("abort_sb_empty", wr_q.size(), 0);

        // Window decode and tandy 32K addressing
        c0 = wr_done;
        tandy_32k = 1'b0;
        cpu_write(20'hBC123, 8'h44, 1'b1, 19'h00123);
        tandy_32k = 1'b1;
        cpu_write(20'hBC123, 8'h45, 1'b1, 19'h04123);
        tandy_32k = 1'b0;
        cpu_write(20'hC0000, 8'h46, 1'b0, 19'h0);
        bus_aen = 1'b1;
        cpu_write(20'hB8000, 8'h47, 1'b0, 19'h0);
        bus_aen = 1'b0;
        step(6);
        check_eq("decode_count", wr_done, c0 + 2);
        check_eq("decode_sb_empty", wr_q.size(), 0);

        // Reset in the middle of a write access discards buffered work
        isa_op_enable = 1'b0;
        cpu_write(20'hB8040, 8'h51, 1'b1, 19'h00040);
        cpu_write(20'hB8041, 8'h52, 1'b1, 19'h00041);
        c0 = wr_done;
        isa_op_enable = 1'b1;
        wait_we_low(10, "rst_mid_start");
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_we", ram_we_l, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        wr_q.delete();
        step(12);
        check_eq("rst_fifo_empty", wr_done, c0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_nw_ovf", nw_overflow, 0);
        check_eq("rst_mid_rdy", bus_rdy, 1);

        check_eq("nw_rdy_const", nw_rdy_low_cnt, 0);
        check_eq("final_rd_q", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
